// File: rtl/proc_control_fsm.sv
// ============================================================================
//  Module      : proc_control_fsm
//  Description : Instruction fetch/decode/execute sequencer for the enhanced
//                processor; drives the one-hot bus mux and datapath strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_control_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic       Clock_i,
    input  logic       Resetn_i,
    input  logic       Run_i,
    input  logic [8:0] IR_i,
    input  logic       G_nz_i,
    output logic [9:0] muxSeletor_o,
    output logic       DINout_o,
    output logic       Gout_o,
    output logic [7:0] Rout_o,
    output logic [7:0] Rin_o,
    output logic       Ain_o,
    output logic       Gin_o,
    output logic       AddSub_o,
    output logic       IRin_o,
    output logic       ADDRin_o,
    output logic       DOUTin_o,
    output logic       W_D_o,
    output logic       incr_pc_o,
    output logic       Done_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_ADDR = 3'd1,
        ST_F_WAIT = 3'd2,
        ST_F_IR   = 3'd3,
        ST_EX1    = 3'd4,
        ST_EX2    = 3'd5,
        ST_WAIT   = 3'd6,
        ST_EX3    = 3'd7
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    localparam logic       HAS_WAIT  = (MEM_WAIT > 0);

    localparam logic [9:0] SRC_DIN = 10'b00_0000_0001;
    localparam logic [9:0] SRC_G   = 10'b00_0000_0010;

    state_t     state_q, state_d;
    logic [1:0] wcnt_q, wcnt_d;

    logic [2:0] op_w, x_w, y_w;
    logic [7:0] rin_x_w;
    logic [9:0] src_rx_w, src_ry_w, src_r7_w;

    assign op_w     = IR_i[8:6];
    assign x_w      = IR_i[5:3];
    assign y_w      = IR_i[2:0];
    assign rin_x_w  = 8'b1 << x_w;
    assign src_rx_w = 10'b100 << x_w;
    assign src_ry_w = 10'b100 << y_w;
    assign src_r7_w = 10'b10_0000_0000;

    always_ff @(posedge Clock_i) begin
        if (!Resetn_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        muxSeletor_o = 10'd0;
        Rin_o        = 8'd0;
        Ain_o        = 1'b0;
        Gin_o        = 1'b0;
        AddSub_o     = 1'b0;
        IRin_o       = 1'b0;
        ADDRin_o     = 1'b0;
        DOUTin_o     = 1'b0;
        W_D_o        = 1'b0;
        incr_pc_o    = 1'b0;
        Done_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Run_i) state_d = ST_F_ADDR;
            end
            ST_F_ADDR: begin
                muxSeletor_o = src_r7_w;
                ADDRin_o     = 1'b1;
                incr_pc_o    = 1'b1;
                state_d      = HAS_WAIT ? ST_F_WAIT : ST_F_IR;
            end
            ST_F_WAIT, ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d  = 2'd0;
                    state_d = (state_q == ST_F_WAIT) ? ST_F_IR : ST_EX3;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_F_IR: begin
                IRin_o  = 1'b1;
                state_d = ST_EX1;
            end
            ST_EX1: begin
                case (op_w)
                    3'b000: begin
                        muxSeletor_o = src_ry_w;
                        Rin_o        = rin_x_w;
                        Done_o       = 1'b1;
                    end
                    3'b001: begin
                        muxSeletor_o = src_r7_w;
                        ADDRin_o     = 1'b1;
                        incr_pc_o    = 1'b1;
                        state_d      = HAS_WAIT ? ST_WAIT : ST_EX3;
                    end
                    3'b010, 3'b011: begin
                        muxSeletor_o = src_rx_w;
                        Ain_o        = 1'b1;
                        state_d      = ST_EX2;
                    end
                    3'b100: begin
                        muxSeletor_o = src_ry_w;
                        ADDRin_o     = 1'b1;
                        state_d      = HAS_WAIT ? ST_WAIT : ST_EX3;
                    end
                    3'b101: begin
                        muxSeletor_o = src_ry_w;
                        ADDRin_o     = 1'b1;
                        state_d      = ST_EX2;
                    end
                    3'b110: begin
                        // mvnz without a nonzero G still retires, just with no transfer
                        if (G_nz_i) begin
                            muxSeletor_o = src_ry_w;
                            Rin_o        = rin_x_w;
                        end
                        Done_o = 1'b1;
                    end
                    default: Done_o = 1'b1;
                endcase
            end
            ST_EX2: begin
                if (op_w == 3'b101) begin
                    muxSeletor_o = src_rx_w;
                    DOUTin_o     = 1'b1;
                    W_D_o        = 1'b1;
                    Done_o       = 1'b1;
                end else begin
                    muxSeletor_o = src_ry_w;
                    Gin_o        = 1'b1;
                    AddSub_o     = op_w[0];
                    state_d      = ST_EX3;
                end
            end
            ST_EX3: begin
                muxSeletor_o = (op_w[2:1] == 2'b01) ? SRC_G : SRC_DIN;
                Rin_o        = rin_x_w;
                Done_o       = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (Done_o) state_d = Run_i ? ST_F_ADDR : ST_IDLE;
    end

    assign DINout_o = muxSeletor_o[0];
    assign Gout_o   = muxSeletor_o[1];
    assign Rout_o   = muxSeletor_o[9:2];

endmodule

`default_nettype wire

// File: tb/tb_proc_control_fsm.sv
// ============================================================================
//  Module      : tb_proc_control_fsm
//  Description : Scoreboard bench for proc_control_fsm at MEM_WAIT = 0, 1, 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [3];
    logic       run  [3];
    logic [8:0] ir   [3];
    logic       gnz  [3];
    logic [36:0] obs [3];

    logic [36:0] exq [$];
    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int MW = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
        logic [9:0] mux_w;
        logic [7:0] rout_w, rin_w;
        logic dinout_w, gout_w, ain_w, gin_w, as_w, irin_w, addrin_w;
        logic doutin_w, wd_w, incr_w, done_w;

        proc_control_fsm #(.MEM_WAIT(MW)) u_dut (
            .Clock_i      (clk),
            .Resetn_i     (rstn[k]),
            .Run_i        (run[k]),
            .IR_i         (ir[k]),
            .G_nz_i       (gnz[k]),
            .muxSeletor_o (mux_w),
            .DINout_o     (dinout_w),
            .Gout_o       (gout_w),
            .Rout_o       (rout_w),
            .Rin_o        (rin_w),
            .Ain_o        (ain_w),
            .Gin_o        (gin_w),
            .AddSub_o     (as_w),
            .IRin_o       (irin_w),
            .ADDRin_o     (addrin_w),
            .DOUTin_o     (doutin_w),
            .W_D_o        (wd_w),
            .incr_pc_o    (incr_w),
            .Done_o       (done_w)
        );

        assign obs[k] = {mux_w, dinout_w, gout_w, rout_w, rin_w, ain_w, gin_w, as_w,
                         irin_w, addrin_w, doutin_w, wd_w, incr_w, done_w};
    end

    task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] rsel(input logic [2:0] r);
        logic [9:0] one = 10'd1;
        return one << (int'(r) + 2);
    endfunction

    function automatic logic [36:0] vec(input logic [9:0] mux, input logic [7:0] rin,
                                        input logic [8:0] strobes);
        // strobes = {Ain, Gin, AddSub, IRin, ADDRin, DOUTin, W_D, incr_pc, Done}
        return {mux, mux[0], mux[1], mux[9:2], rin, strobes};
    endfunction

    localparam logic [8:0] S_AIN  = 9'b1_0000_0000;
    localparam logic [8:0] S_GIN  = 9'b0_1000_0000;
    localparam logic [8:0] S_SUB  = 9'b0_0100_0000;
    localparam logic [8:0] S_IRIN = 9'b0_0010_0000;
    localparam logic [8:0] S_ADDR = 9'b0_0001_0000;
    localparam logic [8:0] S_DOUT = 9'b0_0000_1000;
    localparam logic [8:0] S_WD   = 9'b0_0000_0100;
    localparam logic [8:0] S_INC  = 9'b0_0000_0010;
    localparam logic [8:0] S_DONE = 9'b0_0000_0001;
    localparam logic [9:0] M_DIN  = 10'b00_0000_0001;
    localparam logic [9:0] M_G    = 10'b00_0000_0010;

    task automatic push_instr(input int mw, input logic [8:0] instr, input logic g);
        logic [2:0] op = instr[8:6];
        logic [2:0] x  = instr[5:3];
        logic [2:0] y  = instr[2:0];
        logic [7:0] rx = 8'd1 << x;
        exq.push_back(vec(rsel(3'd7), 8'd0, S_ADDR | S_INC));
        repeat (mw) exq.push_back('0);
        exq.push_back(vec(10'd0, 8'd0, S_IRIN));
        case (op)
            3'd0: exq.push_back(vec(rsel(y), rx, S_DONE));
            3'd1: begin
                exq.push_back(vec(rsel(3'd7), 8'd0, S_ADDR | S_INC));
                repeat (mw) exq.push_back('0);
                exq.push_back(vec(M_DIN, rx, S_DONE));
            end
            3'd2, 3'd3: begin
                exq.push_back(vec(rsel(x), 8'd0, S_AIN));
                exq.push_back(vec(rsel(y), 8'd0, S_GIN | (op[0] ? S_SUB : 9'd0)));
                exq.push_back(vec(M_G, rx, S_DONE));
            end
            3'd4: begin
                exq.push_back(vec(rsel(y), 8'd0, S_ADDR));
                repeat (mw) exq.push_back('0);
                exq.push_back(vec(M_DIN, rx, S_DONE));
            end
            3'd5: begin
                exq.push_back(vec(rsel(y), 8'd0, S_ADDR));
                exq.push_back(vec(rsel(x), 8'd0, S_DOUT | S_WD | S_DONE));
            end
            3'd6: exq.push_back(g ? vec(rsel(y), rx, S_DONE) : vec(10'd0, 8'd0, S_DONE));
            default: exq.push_back(vec(10'd0, 8'd0, S_DONE));
        endcase
    endtask

    // Entered at a negedge with Run already high; abort_at >= 0 pulls reset after that cycle.
    task automatic do_instr(input int k, input int mw, input logic [8:0] instr, input logic g,
                            input logic run_after, input int abort_at);
        int n;
        logic [36:0] e;
        push_instr(mw, instr, g);
        n = exq.size();
        gnz[k] = g;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            e = exq.pop_front();
            chk($sformatf("k%0d ir%o c%0d", k, instr, c), obs[k], e);
            if (c == mw + 1) ir[k] = instr;
            if (c == n - 1) run[k] = run_after;
            if (c == abort_at) begin
                exq.delete();
                rstn[k] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("k%0d abort_rst", k), obs[k], '0);
                rstn[k] = 1'b1;
                run[k]  = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle_check(input int k, input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("k%0d %s%0d", k, tag, c), obs[k], '0);
        end
    endtask

    task automatic reset_dut(input int k);
        @(negedge clk);
        rstn[k] = 1'b0;
        run[k]  = 1'b1;
        ir[k]   = 9'o777;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("k%0d reset", k), obs[k], '0);
        rstn[k] = 1'b1;
        run[k]  = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0;
            run[k]  = 1'b0;
            ir[k]   = 9'd0;
            gnz[k]  = 1'b0;
        end

        // MEM_WAIT = 1
        reset_dut(1);
        do_instr(1, 1, 9'o035, 1'b0, 1'b1, -1);  // mv  R3,R5
        do_instr(1, 1, 9'o212, 1'b0, 1'b1, -1);  // add R1,R2
        do_instr(1, 1, 9'o312, 1'b0, 1'b1, -1);  // sub R1,R2
        do_instr(1, 1, 9'o521, 1'b0, 1'b1, -1);  // st  R2,[R1]
        do_instr(1, 1, 9'o601, 1'b0, 1'b1, -1);  // mvnz R0,R1 with G=0
        do_instr(1, 1, 9'o601, 1'b1, 1'b1, -1);  // mvnz R0,R1 with G!=0
        do_instr(1, 1, 9'o745, 1'b1, 1'b1, -1);  // reserved
        do_instr(1, 1, 9'o177, 1'b0, 1'b1, -1);  // mvi R7
        do_instr(1, 1, 9'o477, 1'b0, 1'b1, -1);  // ld  R7,[R7]
        do_instr(1, 1, 9'o077, 1'b0, 1'b0, -1);  // mv R7,R7, then Run=0
        idle_check(1, 3, "idle");
        run[1] = 1'b1;
        do_instr(1, 1, 9'o212, 1'b0, 1'b1, 4);   // add aborted in EX2
        idle_check(1, 2, "post_abort");
        run[1] = 1'b1;
        do_instr(1, 1, 9'o035, 1'b0, 1'b0, -1);
        idle_check(1, 1, "end");
        rstn[1] = 1'b0;

        // MEM_WAIT = 0
        reset_dut(0);
        do_instr(0, 0, 9'o100, 1'b0, 1'b1, -1);  // mvi R0
        do_instr(0, 0, 9'o446, 1'b0, 1'b1, -1);  // ld  R4,[R6]
        do_instr(0, 0, 9'o312, 1'b0, 1'b1, -1);
        do_instr(0, 0, 9'o521, 1'b0, 1'b0, -1);
        idle_check(0, 2, "idle");
        rstn[0] = 1'b0;

        // MEM_WAIT = 3
        reset_dut(2);
        do_instr(2, 3, 9'o100, 1'b0, 1'b1, -1);
        do_instr(2, 3, 9'o446, 1'b0, 1'b1, -1);
        do_instr(2, 3, 9'o035, 1'b0, 1'b0, -1);
        idle_check(2, 2, "idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
